wbu_txuart: RTL and testbench

WBU_TXUART -- requirements
Module: wbutxuart

---
 rtl/wbubus_pkg.sv | 5 +
 rtl/wbu_txuart.sv | 55 +++++
 tb/tb_wbu_txuart.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/wbubus_pkg.sv
// wbubus_pkg: shared types and constants for the wishbone-to-uart bus bridge
package wbubus_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} txu_state_t;
  localparam logic [23:0] WBU_CLOCKS_PER_BAUD = 24'd868;
endpackage

// File: rtl/wbu_txuart.sv
// wbu_txuart: 8N1 serial transmitter for the bus-output character stream
module wbu_txuart
  import wbubus_pkg::*;
#(
  parameter logic [23:0] CLOCKS_PER_BAUD = WBU_CLOCKS_PER_BAUD
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_stb,
  input  logic [7:0] i_data,
  output logic       o_busy,
  output logic       o_uart_tx
);
  txu_state_t  state;
  logic [23:0] counter;
  logic [2:0]  index;
  logic [7:0]  sreg;
  // Frame sequencer; busy drops one clock early in STOP so the next byte can start gap-free
  always_ff @(posedge i_clk)
    if (i_reset) begin
      state     <= IDLE;
      counter   <= '0;
      index     <= '0;
      sreg      <= '0;
      o_uart_tx <= 1'b1;
      o_busy    <= 1'b0;
    end else if (i_stb && !o_busy) begin
      state     <= START;
      counter   <= CLOCKS_PER_BAUD - 24'd1;
      index     <= '0;
      sreg      <= i_data;
      o_uart_tx <= 1'b0;
      o_busy    <= 1'b1;
    end else if (state != IDLE) begin
      if (counter != '0) begin
        counter <= counter - 24'd1;
        o_busy  <= !(state == STOP && counter == 24'd1);
      end else begin
        counter <= (state == STOP) ? '0 : CLOCKS_PER_BAUD - 24'd1;
        case (state)
          START: begin
            state     <= DATA;
            index     <= '0;
            o_uart_tx <= sreg[0];
          end
          DATA: begin
            state     <= (index == 3'd7) ? STOP : DATA;
            index     <= index + 3'd1;
            o_uart_tx <= (index == 3'd7) | sreg[index + 3'd1];
          end
          default: state <= IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_wbu_txuart.sv
// tb_wbu_txuart: scoreboard bench with reference 8N1 receivers on a fast and a default-rate transmitter
module tb_wbu_txuart;
  logic clk = 1'b0, rst = 1'b1;
  logic stb_a = 1'b0, stb_b = 1'b0;
  logic [7:0] data_a = '0, data_b = '0;
  logic busy_a, busy_b, tx_a, tx_b;
  int cyc = 0, n_tests = 0, n_fail = 0;
  logic [7:0] q_a[$], q_b[$];

  wbu_txuart #(.CLOCKS_PER_BAUD(24'd4)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_stb(stb_a), .i_data(data_a), .o_busy(busy_a), .o_uart_tx(tx_a));
  wbu_txuart dut_b (
    .i_clk(clk), .i_reset(rst), .i_stb(stb_b), .i_data(data_b), .o_busy(busy_b), .o_uart_tx(tx_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic line(input bit sel);
    return sel ? tx_b : tx_a;
  endfunction

  // reference receiver: every clock of every bit must hold the value seen on its first clock
  task automatic rx_mon(input int cpb, input bit sel);
    logic [9:0] bits;
    logic [7:0] exp;
    bit steady, ab;
    forever begin
      @(negedge clk);
      if (!rst && line(sel) === 1'b0) begin
        steady = 1;
        ab = 0;
        bits = '0;
        for (int k = 0; k < 10 && !ab; k++)
          for (int c = 0; c < cpb && !ab; c++) begin
            if (k > 0 || c > 0) @(negedge clk);
            if (rst) ab = 1;
            else if (c == 0) bits[k] = line(sel);
            else if (line(sel) !== bits[k]) steady = 0;
          end
        if (!ab) begin
          check(sel ? "rx_b_steady" : "rx_a_steady", {31'd0, steady}, 1);
          check(sel ? "rx_b_framing" : "rx_a_framing", {30'd0, bits[9], bits[0]}, 2);
          if (sel ? q_b.size() == 0 : q_a.size() == 0)
            check(sel ? "rx_b_unexpected" : "rx_a_unexpected", {24'd0, bits[8:1]}, 32'hFFFF_FFFF);
          else begin
            exp = sel ? q_b.pop_front() : q_a.pop_front();
            check(sel ? "rx_b_byte" : "rx_a_byte", {24'd0, bits[8:1]}, {24'd0, exp});
          end
        end
      end
    end
  endtask

  initial rx_mon(4, 1'b0);
  initial rx_mon(868, 1'b1);

  // raises stb with d, waits for acceptance, returns at clock 1 of the frame with stb still high
  task automatic send(input bit sel, input logic [7:0] d, input bit exp, output int acc);
    int w;
    w = 0;
    if (sel) begin stb_b = 1'b1; data_b = d; end
    else begin stb_a = 1'b1; data_a = d; end
    while ((sel ? busy_b : busy_a) && w < 20000) begin
      @(negedge clk);
      w++;
    end
    check("send_wait", {31'd0, w < 20000}, 1);
    if (exp) begin
      if (sel) q_b.push_back(d);
      else q_a.push_back(d);
    end
    @(negedge clk);
    acc = cyc;
  endtask

  initial begin
    int a, b, bad;
    logic [7:0] pat;
    logic ex;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_a", {30'd0, busy_a, tx_a}, 1);
    check("reset_b", {30'd0, busy_b, tx_b}, 1);
    // single 0x55 frame, clock-by-clock
    pat = 8'h55;
    send(1'b0, pat, 1'b1, a);
    stb_a = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      ex = (n <= 4) ? 1'b0 : (n <= 36) ? pat[(n - 5) / 4] : 1'b1;
      check("t1_tx", {31'd0, tx_a}, {31'd0, ex});
      check("t1_busy", {31'd0, busy_a}, {31'd0, n != 40});
      @(negedge clk);
    end
    check("t1_idle", {30'd0, busy_a, tx_a}, 1);
    // back-to-back with stb held high, data changed right after the first accept
    repeat (5) @(negedge clk);
    send(1'b0, 8'h41, 1'b1, a);
    send(1'b0, 8'h0A, 1'b1, b);
    stb_a = 1'b0;
    check("t2_second_start", b - a, 40);
    check("t2_start_low", {31'd0, tx_a}, 0);
    repeat (38) @(negedge clk);
    check("t2_busy_79", {31'd0, busy_a}, 1);
    @(negedge clk);
    check("t2_end_80", {30'd0, busy_a, tx_a}, 1);
    // stb with 0xFF during the DATA phase of 0x00 is ignored
    repeat (5) @(negedge clk);
    send(1'b0, 8'h00, 1'b1, a);
    data_a = 8'hFF;
    repeat (15) @(negedge clk);
    stb_a = 1'b0;
    repeat (70) @(negedge clk);
    check("t3_queue_empty", q_a.size(), 0);
    check("t3_idle", {30'd0, busy_a, tx_a}, 1);
    // reset at clock 15 of an 0xA5 frame, with a competing stb
    send(1'b0, 8'hA5, 1'b0, a);
    stb_a = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    stb_a = 1'b1;
    data_a = 8'h33;
    @(negedge clk);
    rst = 1'b0;
    stb_a = 1'b0;
    check("t4_after_reset", {30'd0, busy_a, tx_a}, 1);
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0) bad++;
    end
    check("t4_hold_high", bad, 0);
    send(1'b0, 8'h3C, 1'b1, a);
    stb_a = 1'b0;
    repeat (45) @(negedge clk);
    check("t4_recover_queue", q_a.size(), 0);
    // default rate, 0x0D
    send(1'b1, 8'h0D, 1'b1, a);
    stb_b = 1'b0;
    bad = 0;
    while (busy_b && bad < 9000) begin
      @(negedge clk);
      bad++;
    end
    check("t5_frame_len", cyc - a + 1, 8680);
    check("t5_stop_high", {31'd0, tx_b}, 1);
    repeat (5) @(negedge clk);
    check("final_queues_empty", q_a.size() + q_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
